// File: rtl/game_369_judge.sv
// Referee for an upstream 369 counter: claps on 3/6/9/13, tracks the
// 3-6-9-13 cycle, and reports the sample as two BCD digits.
module game_369_judge (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] count,
    input  logic       count_valid,
    output logic       clap,
    output logic [7:0] clap_total,
    output logic       locked,
    output logic       seq_error,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones
);

    typedef enum logic [2:0] {
        SYNC,
        EXP6,
        EXP9,
        EXP13,
        ERR
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       hit;
    logic [3:0] tens_nxt;
    logic [3:0] ones_nxt;

    always_comb begin
        hit = (count == 4'd3) || (count == 4'd6) ||
              (count == 4'd9) || (count == 4'd13);

        if (count >= 4'd10) begin
            tens_nxt = 4'd1;
            ones_nxt = count - 4'd10;
        end else begin
            tens_nxt = 4'd0;
            ones_nxt = count;
        end

        // Only SYNC and ERR resync on 3; once locked, a 3 is a violation.
        state_nxt = state;
        unique case (state)
            SYNC:    if (count == 4'd3) state_nxt = EXP6;
            EXP6:    state_nxt = (count == 4'd6)  ? EXP9  : ERR;
            EXP9:    state_nxt = (count == 4'd9)  ? EXP13 : ERR;
            EXP13:   state_nxt = (count == 4'd13) ? EXP6  : ERR;
            ERR:     if (count == 4'd3) state_nxt = EXP6;
            default: state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SYNC;
            clap       <= 1'b0;
            clap_total <= 8'd0;
            locked     <= 1'b0;
            seq_error  <= 1'b0;
            bcd_tens   <= 4'd0;
            bcd_ones   <= 4'd0;
        end else if (count_valid) begin
            state     <= state_nxt;
            clap      <= hit;
            locked    <= (state_nxt == EXP6) || (state_nxt == EXP9) ||
                         (state_nxt == EXP13);
            seq_error <= (state_nxt == ERR);
            bcd_tens  <= tens_nxt;
            bcd_ones  <= ones_nxt;
            if (hit && (clap_total != 8'hff))
                clap_total <= clap_total + 8'd1;
        end else begin
            clap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_game_369_judge.sv
// Directed bench for game_369_judge: the driver queues hand-computed
// responses, a monitor pops one per cycle and compares it.
module tb_game_369_judge;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] count = 4'd0;
    logic       count_valid = 1'b0;
    logic       clap;
    logic [7:0] clap_total;
    logic       locked;
    logic       seq_error;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;

    typedef struct {
        logic       clap;
        logic [7:0] total;
        logic       locked;
        logic       err;
        logic [3:0] tens;
        logic [3:0] ones;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   exp_total = 0;
    int   vectors = 0;
    int   miscompares = 0;

    game_369_judge dut (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .count_valid(count_valid),
        .clap       (clap),
        .clap_total (clap_total),
        .locked     (locked),
        .seq_error  (seq_error),
        .bcd_tens   (bcd_tens),
        .bcd_ones   (bcd_ones)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        if (got != want) begin
            miscompares++;
            $display("FAIL %s vec %0d: got %0d expected %0d",
                     name, vectors, got, want);
        end
    endtask

    // Monitor: an entry queued before this edge describes the outputs
    // that this edge produces; compare them mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                @(negedge clk);
                vectors++;
                check("clap", int'(clap), int'(e.clap));
                check("clap_total", int'(clap_total), int'(e.total));
                check("locked", int'(locked), int'(e.locked));
                check("seq_error", int'(seq_error), int'(e.err));
                check("bcd_tens", int'(bcd_tens), int'(e.tens));
                check("bcd_ones", int'(bcd_ones), int'(e.ones));
            end
        end
    end

    task automatic step(input logic rst, input logic v, input int cnt,
                        input logic ec, input logic el, input logic ee,
                        input int et, input int eo);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = rst;
        count_valid = v;
        count       = 4'(cnt);
        if (rst) exp_total = 0;
        else if (ec && exp_total < 255) exp_total++;
        e.clap   = ec;
        e.total  = 8'(exp_total);
        e.locked = el;
        e.err    = ee;
        e.tens   = 4'(et);
        e.ones   = 4'(eo);
        q.push_back(e);
        last = e;
    endtask

    task automatic do_reset(input logic v, input int cnt);
        step(1'b1, v, cnt, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 4'd3, 1'b0, last.locked, last.err,
                 int'(last.tens), int'(last.ones));
    endtask

    // Valid sample: count, clap, locked, seq_error, tens, ones
    task automatic s(input int c, input logic ec, input logic el,
                     input logic ee, input int et, input int eo);
        step(1'b0, 1'b1, c, ec, el, ee, et, eo);
    endtask

    initial begin
        int waited;
        do_reset(1'b0, 0);
        do_reset(1'b0, 0);

        // Nominal cycle, wrapping 13 -> 6
        s(0,  0, 0, 0, 0, 0);
        s(3,  1, 1, 0, 0, 3);
        s(6,  1, 1, 0, 0, 6);
        s(9,  1, 1, 0, 0, 9);
        s(13, 1, 1, 0, 1, 3);
        s(6,  1, 1, 0, 0, 6);
        s(9,  1, 1, 0, 0, 9);
        s(13, 1, 1, 0, 1, 3);

        // Valid gap mid-sequence, then continue
        hold(5);
        s(6,  1, 1, 0, 0, 6);
        s(9,  1, 1, 0, 0, 9);
        s(13, 1, 1, 0, 1, 3);
        s(6,  1, 1, 0, 0, 6);

        // Wrong value in EXP9, stay in ERR, recover on 3
        s(6,  1, 0, 1, 0, 6);
        s(9,  1, 0, 1, 0, 9);
        s(10, 0, 0, 1, 1, 0);
        s(3,  1, 1, 0, 0, 3);

        // 3 while expecting 6 is a violation
        s(3,  1, 0, 1, 0, 3);
        s(3,  1, 1, 0, 0, 3);
        s(6,  1, 1, 0, 0, 6);
        s(9,  1, 1, 0, 0, 9);

        // Reset wins over a valid 3 while in EXP13
        do_reset(1'b1, 3);
        s(3,  1, 1, 0, 0, 3);

        // SYNC tolerates non-3 values
        do_reset(1'b0, 0);
        s(5,  0, 0, 0, 0, 5);
        s(15, 0, 0, 0, 1, 5);
        s(12, 0, 0, 0, 1, 2);
        s(13, 1, 0, 0, 1, 3);

        // Saturation: 300 claps in SYNC
        do_reset(1'b0, 0);
        for (int i = 0; i < 300; i++)
            s(9, 1, 0, 0, 0, 9);
        hold(2);
        s(9,  1, 0, 0, 0, 9);
        s(4,  0, 0, 0, 0, 4);
        hold(1);

        waited = 0;
        while (q.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/game_369_judge.md
GAME_369_JUDGE -- requirements
Module: game_369_judge

Interface
REQ-001 Ports SHALL be as listed below; one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising clk.
REQ-004 count  input  4  value from the upstream 369 counter, binary 0..15.
REQ-005 count_valid  input  1  count is sampled only on edges where this is 1.
REQ-006 clap  output  1  one-cycle pulse: the last sampled value has a decimal ones digit of 3, 6 or 9.
REQ-007 clap_total  output  8  saturating count of clap pulses since reset.
REQ-008 locked  output  1  FSM is tracking the 3-6-9-13 sequence.
REQ-009 seq_error  output  1  sticky sequence-violation flag.
REQ-010 bcd_tens  output  4  registered decimal tens digit of the last sampled count (0 or 1).
REQ-011 bcd_ones  output  4  registered decimal ones digit of the last sampled count (0..9).

Function
REQ-012 All outputs SHALL be registered; each response SHALL appear on the rising edge that samples count_valid=1 (visible the following cycle, latency 1).
REQ-013 Edges with count_valid=0 SHALL hold all state and outputs, except clap, which SHALL return to 0.
REQ-014 BCD: count>=10 SHALL give bcd_tens=1 and bcd_ones=count-10; otherwise bcd_tens=0 and bcd_ones=count.
REQ-015 clap SHALL pulse for exactly the sampled values 3, 6, 9 and 13, in every FSM state.
REQ-016 clap_total SHALL increment by 1 on each clap pulse.
REQ-017 clap_total SHALL saturate at 255, with no wrap.
REQ-018 FSM states SHALL be SYNC, EXP6, EXP9, EXP13 and ERR.
REQ-019 SYNC: sampled 3 -> EXP6; any other value -> stay in SYNC with no error (upstream reset value 0 is tolerated).
REQ-020 EXP6: 6 -> EXP9.
REQ-021 EXP9: 9 -> EXP13.
REQ-022 EXP13: 13 -> EXP6 (the sequence wraps to 6, never back to 3).
REQ-023 In EXP6, EXP9 or EXP13, any value other than the expected one SHALL go to ERR and set seq_error=1.
REQ-024 ERR: sampled 3 -> EXP6 and clears seq_error; any other value -> stay in ERR.
REQ-025 locked SHALL be 1 exactly when the state is EXP6, EXP9 or EXP13.
REQ-026 A sampled 3 while in EXP6 SHALL be an error, not a resync.
REQ-027 State transitions and the clap/BCD/clap_total updates for the same sample SHALL occur on the same edge.

Reset
REQ-028 reset=1 SHALL take priority over count_valid on the same edge.
REQ-029 On reset: state=SYNC, clap=0, clap_total=0, locked=0, seq_error=0, bcd_tens=0, bcd_ones=0.
REQ-030 Reset asserted mid-sequence or in ERR SHALL give the same reset values, with no residual state.
REQ-031 The first valid sample after reset deassertion SHALL be processed normally.

Verification
REQ-032 Reset, then valid stream 0,3,6,9,13,6,9,13 -> clap pattern 0,1,1,1,1,1,1,1; clap_total=7; locked=1 from the sample of 3 onward; seq_error stays 0.
REQ-033 Locked in EXP9, sample 6 -> seq_error=1 and locked=0 next cycle; then sample 9 -> stays in ERR; then sample 3 -> seq_error=0 and locked=1.
REQ-034 Sample 13 -> bcd_tens=1, bcd_ones=3.
REQ-035 Sample 9 -> bcd_tens=0, bcd_ones=9.
REQ-036 Sample 10 -> bcd_tens=1, bcd_ones=0, clap=0.
REQ-037 300 clapping samples -> clap_total reads 255 and holds.
REQ-038 count_valid gated low for 5 cycles mid-sequence -> outputs hold, clap=0, and the sequence continues without error.
REQ-039 reset=1 together with count_valid=1 and count=3 while in EXP13 -> all outputs are at reset values next cycle and state=SYNC.
